// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
//
// Shared constants and constant functions for the pipelined CORDIC sin/cos
// core. Every value is evaluated at elaboration time. The arithmetic is
// plain 64-bit integer fixed point with 60 fractional bits. It needs no
// real-number support from the synthesis tool.
//
//   atan_q(i, frac_bits)      round(atan(2^-i) * 2^frac_bits)
//   gain_q(stages, frac_bits) round(prod cos(atan 2^-i) * 2^frac_bits)
//   pi_q(frac_bits)           round(pi   * 2^frac_bits)   (PI_Q)
//   half_pi_q(frac_bits)      round(pi/2 * 2^frac_bits)   (HALF_PI_Q)
//   one_q(frac_bits)          2^frac_bits                  (ONE)
//
// The stage payload {x, y, z, neg, valid, tag} depends on the WIDTH, GUARD
// and TAG_W parameters of the instantiating module. A package cannot hold a
// parameterised typedef. For that reason the payload is declared in
// cordic_sincos_pipe and passed to cordic_stage as a type parameter.
// ---------------------------------------------------------------------------
package cordic_pkg;

    // Binary point of the high-precision elaboration-time arithmetic.
    localparam int FP_BITS = 60;

    // atan(1/n) * 2^FP_BITS, computed with the alternating Taylor series.
    // Requires n >= 2.
    function automatic longint atan_inv_fp(input longint n);
        longint p;
        longint acc;
        acc = 0;
        p   = (longint'(1) <<< FP_BITS) / n;
        for (int k = 0; k < 64; k++) begin
            if (k[0] == 1'b0) acc = acc + p / longint'(2 * k + 1);
            else              acc = acc - p / longint'(2 * k + 1);
            p = p / (n * n);
        end
        return acc;
    endfunction

    // pi/4 * 2^FP_BITS, using Machin's formula.
    function automatic longint quarter_pi_fp();
        return 4 * atan_inv_fp(5) - atan_inv_fp(239);
    endfunction

    // Round a positive FP_BITS-scaled value to frac_bits fractional bits.
    function automatic longint round_to(input longint v, input int frac_bits);
        int sh;
        sh = FP_BITS - frac_bits;
        return (v + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic longint atan_q(input int i, input int frac_bits);
        if (i == 0)  return round_to(quarter_pi_fp(), frac_bits);
        // Beyond 30 the series base overflows. atan(x) == x to far below
        // one LSB at that point, so the shifted value is used directly.
        if (i >= 31) return round_to(longint'(1) <<< (FP_BITS - i), frac_bits);
        return round_to(atan_inv_fp(longint'(1) <<< i), frac_bits);
    endfunction

    function automatic longint pi_q(input int frac_bits);
        return round_to(4 * quarter_pi_fp(), frac_bits);
    endfunction

    function automatic longint half_pi_q(input int frac_bits);
        return round_to(2 * quarter_pi_fp(), frac_bits);
    endfunction

    function automatic longint one_q(input int frac_bits);
        return longint'(1) <<< frac_bits;
    endfunction

    // Gain compensation 1/An = 1/sqrt(prod(1 + 4^-i)). The product P is
    // built by shift-add. The result is 2^(frac+30) / isqrt(P), rounded.
    function automatic longint gain_q(input int stages, input int frac_bits);
        longint p;
        longint s;
        longint t;
        p = longint'(1) <<< FP_BITS;
        for (int i = 0; i < stages; i++) p = p + (p >>> (2 * i));
        s = 0;
        for (int b = 31; b >= 0; b--) begin
            t = s | (longint'(1) <<< b);
            if (t * t <= p) s = t;
        end
        return ((longint'(1) <<< (frac_bits + 31)) / s + 1) >>> 1;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// ---------------------------------------------------------------------------
// cordic_stage
//
// This is one registered CORDIC micro-rotation in rotation mode. The
// residual angle z selects the direction of rotation. neg, valid and tag
// pass through unchanged, so they stay with their sample.
//
// Parameters
//   payload_t  stage payload struct {x, y, z, neg, valid, tag}
//   DW         internal datapath width (WIDTH + GUARD)
//   SHIFT      stage index i; the arithmetic shift applied to x and y
//   ATAN       round(atan(2^-i) * 2^(FRAC+GUARD))
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears the stage register
//   enable     clock enable; 0 holds the register
//   stage_i    payload from the previous stage
//   stage_o    registered payload to the next stage
// ---------------------------------------------------------------------------
module cordic_stage #(
    parameter type           payload_t = logic,
    parameter int            DW        = 24,
    parameter int            SHIFT     = 0,
    parameter logic [DW-1:0] ATAN      = '0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     enable,
    input  payload_t stage_i,
    output payload_t stage_o
);

    payload_t             stage_d;
    payload_t             stage_q;
    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;

    // NOTE: every always_comb output gets a full default first (here a copy of
    // the input), so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        stage_d = stage_i;
        x_sh    = $signed(stage_i.x) >>> SHIFT;
        y_sh    = $signed(stage_i.y) >>> SHIFT;
        if (stage_i.z[DW-1]) begin
            // Negative residual angle: rotate clockwise.
            stage_d.x = stage_i.x + y_sh;
            stage_d.y = stage_i.y - x_sh;
            stage_d.z = stage_i.z + ATAN;
        end else begin
            stage_d.x = stage_i.x - y_sh;
            stage_d.y = stage_i.y + x_sh;
            stage_d.z = stage_i.z - ATAN;
        end
    end

    // NOTE: clocked state uses non-blocking assignment only, so every stage
    // samples its neighbour's old value on the same edge.
    // NOTE: the whole payload, including data, is reset. Clearing valid alone
    // would be enough for correctness, but clearing everything keeps reset
    // state deterministic.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else if (enable) begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/cordic_sincos_pipe.sv
// ---------------------------------------------------------------------------
// cordic_sincos_pipe
//
// This is a fully unrolled, pipelined rotation-mode CORDIC. It produces cos
// and sin of a signed Q2.FRAC angle (FRAC = WIDTH-3) over [-pi, pi).
//
// The pipeline is:
//   pre-rotation register -> STAGES x cordic_stage -> output register.
// Latency is STAGES+2 enabled edges, and the core accepts one sample per
// enabled cycle. The pre-rotation step folds angles beyond +-pi/2 by pi and
// sets a neg flag. The output register negates both results when neg is set.
// GUARD must be at least 1.
//
// Build option
//   CORDIC_ROUND_EN  defined: the guard bits are dropped with round-half-up.
//                    undefined (default): they are dropped by truncation
//                    (floor).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears the whole pipeline
//   enable     global clock enable; 0 freezes every register
//   in_valid   sample valid (sampled only when enable=1)
//   in_angle   signed Q2.FRAC angle in radians
//   in_tag     opaque tag returned with the result
//   out_valid  result valid
//   out_cos    signed Q2.FRAC cos, saturated to [-1, +1]
//   out_sin    signed Q2.FRAC sin, saturated to [-1, +1]
//   out_tag    tag of the sample currently on out_*
// ---------------------------------------------------------------------------
module cordic_sincos_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 22,
    parameter int STAGES = 16,
    parameter int GUARD  = 2,
    parameter int TAG_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_angle,
    input  logic        [TAG_W-1:0] in_tag,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_cos,
    output logic signed [WIDTH-1:0] out_sin,
    output logic        [TAG_W-1:0] out_tag
);

    localparam int DW   = WIDTH + GUARD;
    localparam int FRAC = WIDTH - 3;
    localparam int FI   = FRAC + GUARD;

    localparam logic signed [WIDTH-1:0] PI_Q      = WIDTH'(pi_q(FRAC));
    localparam logic signed [WIDTH-1:0] HALF_PI_Q = WIDTH'(half_pi_q(FRAC));
    localparam logic signed [WIDTH-1:0] ONE       = WIDTH'(one_q(FRAC));
    localparam logic signed [DW:0]      ONE_EXT   = (DW + 1)'(one_q(FRAC));
    localparam logic signed [DW-1:0]    K_Q       = DW'(gain_q(STAGES, FI));

    typedef struct packed {
        logic signed [DW-1:0]    x;
        logic signed [DW-1:0]    y;
        logic signed [DW-1:0]    z;
        logic                    neg;
        logic                    valid;
        logic        [TAG_W-1:0] tag;
    } payload_t;

    // ---------------- pre-rotation register --------------------------------
    payload_t                pre_d;
    payload_t                pre_q;
    logic signed [WIDTH-1:0] angle_adj;

    // Fold the angle into [-pi/2, pi/2]. The rotation by pi is applied later
    // as a sign flip of both results. Exactly +-HALF_PI_Q is not folded.
    always_comb begin
        pre_d     = '0;
        angle_adj = in_angle;
        if (in_angle > HALF_PI_Q) begin
            angle_adj = in_angle - PI_Q;
            pre_d.neg = 1'b1;
        end else if (in_angle < -HALF_PI_Q) begin
            angle_adj = in_angle + PI_Q;
            pre_d.neg = 1'b1;
        end
        pre_d.x     = K_Q;
        pre_d.y     = '0;
        pre_d.z     = {angle_adj, {GUARD{1'b0}}};
        pre_d.valid = in_valid;
        pre_d.tag   = in_tag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else if (enable) begin
            pre_q <= pre_d;
        end
    end

    // ---------------- micro-rotation stages --------------------------------
    payload_t pipe [STAGES+1];

    assign pipe[0] = pre_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        cordic_stage #(
            .payload_t (payload_t),
            .DW        (DW),
            .SHIFT     (i),
            .ATAN      (DW'(atan_q(i, FI)))
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable),
            .stage_i (pipe[i]),
            .stage_o (pipe[i+1])
        );
    end

    // ---------------- output register --------------------------------------
    // Drop the guard bits, saturate to [-ONE, ONE], then undo the fold. The
    // extra top bit keeps the rounding add from wrapping.
    function automatic logic signed [WIDTH-1:0] to_port(
        input logic signed [DW-1:0] v,
        input logic                 neg
    );
        logic signed [DW:0]      ext;
        logic signed [WIDTH-1:0] sat;
        ext = {v[DW-1], v};
`ifdef CORDIC_ROUND_EN
        ext = ext + (DW + 1)'(1 <<< (GUARD - 1));
`endif
        ext = ext >>> GUARD;
        if (ext > ONE_EXT) begin
            sat = ONE;
        end else if (ext < -ONE_EXT) begin
            sat = -ONE;
        end else begin
            sat = ext[WIDTH-1:0];
        end
        return neg ? -sat : sat;
    endfunction

    logic                    out_valid_d;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_cos_d;
    logic signed [WIDTH-1:0] out_cos_q;
    logic signed [WIDTH-1:0] out_sin_d;
    logic signed [WIDTH-1:0] out_sin_q;
    logic        [TAG_W-1:0] out_tag_d;
    logic        [TAG_W-1:0] out_tag_q;

    always_comb begin
        out_valid_d = pipe[STAGES].valid;
        out_tag_d   = pipe[STAGES].tag;
        out_cos_d   = to_port(pipe[STAGES].x, pipe[STAGES].neg);
        out_sin_d   = to_port(pipe[STAGES].y, pipe[STAGES].neg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_cos_q   <= '0;
            out_sin_q   <= '0;
            out_tag_q   <= '0;
        end else if (enable) begin
            out_valid_q <= out_valid_d;
            out_cos_q   <= out_cos_d;
            out_sin_q   <= out_sin_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_cos   = out_cos_q;
    assign out_sin   = out_sin_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// ---------------------------------------------------------------------------
// tb_cordic_sincos_pipe
//
// A reference model predicts every output cycle. It is a delay line of
// LAT entries that advances only on enabled edges and is cleared by reset.
// Each entry is computed from the algorithm's rules:
//   - the residual angle z is tracked as an integer, using constants
//     computed here with real math;
//   - x and y are carried as unquantised reals;
//   - the result is rounded to the nearest output LSB.
//
// The directed cases are also compared with the true sin/cos. That
// comparison uses a wider bound, because the residual angle after 16 stages
// can reach atan(2^-15), which is about 16 output LSB.
// ---------------------------------------------------------------------------
module tb_cordic_sincos_pipe;

    localparam int WIDTH     = 22;
    localparam int STAGES    = 16;
    localparam int GUARD     = 2;
    localparam int TAG_W     = 8;
    localparam int FRAC      = WIDTH - 3;
    localparam int LAT       = STAGES + 2;
    localparam int ONE       = 1 << FRAC;
    localparam int VAL_TOL   = 4;
    localparam int IDEAL_TOL = 24;
    localparam real PI_R     = 3.14159265358979323846;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_angle;
    logic        [TAG_W-1:0] in_tag;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_cos;
    logic signed [WIDTH-1:0] out_sin;
    logic        [TAG_W-1:0] out_tag;

    cordic_sincos_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .GUARD  (GUARD),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_angle  (in_angle),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_cos   (out_cos),
        .out_sin   (out_sin),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int c;
        int s;
        int tag;
    } exp_t;

    exp_t   line_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_out    = 0;
    int     pi_m;
    int     half_pi_m;
    longint atan_tab [STAGES];
    real    k_gain;

    task automatic check(input string name, input longint obs, input longint exp,
                         input longint tol = 0);
        longint d;
        n_checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, obs, exp, tol);
        end
    endtask

    function automatic int quant(input real v, input bit neg);
        real r;
        int  q;
        r = v * real'(ONE);
        q = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
        if (q > ONE)  q = ONE;
        if (q < -ONE) q = -ONE;
        return neg ? -q : q;
    endfunction

    // Rotation-mode CORDIC: z is exact integer, x/y are ideal reals.
    function automatic void model(input int ang, output int c, output int s);
        longint z;
        bit     neg;
        real    x, y, xn, sc;
        neg = 1'b0;
        z   = ang;
        if (ang > half_pi_m) begin
            z = ang - pi_m;  neg = 1'b1;
        end else if (ang < -half_pi_m) begin
            z = ang + pi_m;  neg = 1'b1;
        end
        z  = z * (longint'(1) << GUARD);
        x  = k_gain;
        y  = 0.0;
        sc = 1.0;
        for (int i = 0; i < STAGES; i++) begin
            if (z >= 0) begin
                xn = x - y * sc;  y = y + x * sc;  z = z - atan_tab[i];
            end else begin
                xn = x + y * sc;  y = y - x * sc;  z = z + atan_tab[i];
            end
            x  = xn;
            sc = sc / 2.0;
        end
        c = quant(x, neg);
        s = quant(y, neg);
    endfunction

    // One clock: capture what the DUT samples, advance the model, compare.
    task automatic tick();
        bit   r, e, exp_valid;
        exp_t ent;
        r         = reset;
        e         = enable;
        ent.valid = in_valid;
        ent.tag   = int'(in_tag);
        model(int'(in_angle), ent.c, ent.s);
        @(posedge clk);
        #1;
        if (r) begin
            line_q.delete();
        end else if (e) begin
            line_q.push_back(ent);
            if (line_q.size() > LAT) void'(line_q.pop_front());
        end
        exp_valid = 1'b0;
        if (line_q.size() == LAT) exp_valid = line_q[0].valid;
        check("out_valid", longint'(out_valid), longint'(exp_valid));
        if (r) begin
            check("rst_cos", longint'(out_cos), 0);
            check("rst_sin", longint'(out_sin), 0);
            check("rst_tag", longint'(out_tag), 0);
        end else if (exp_valid) begin
            n_out++;
            check("cos", longint'(out_cos), longint'(line_q[0].c), VAL_TOL);
            check("sin", longint'(out_sin), longint'(line_q[0].s), VAL_TOL);
            check("tag", longint'(out_tag), longint'(line_q[0].tag));
        end
    endtask

    task automatic directed(input string name, input int ang, input int tag,
                            input int ec, input int es);
        int n;
        in_valid = 1'b1;
        in_angle = WIDTH'(ang);
        in_tag   = TAG_W'(tag);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, LAT);
        check({name, "_cos_ideal"}, longint'(out_cos), ec, IDEAL_TOL);
        check({name, "_sin_ideal"}, longint'(out_sin), es, IDEAL_TOL);
        check({name, "_tag"}, longint'(out_tag), tag);
    endtask

    function automatic int rand_angle();
        return int'($urandom_range(2 * pi_m - 1, 0)) - pi_m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int bnd [8];
        real sc;

        pi_m      = $rtoi(PI_R * real'(ONE) + 0.5);
        half_pi_m = $rtoi(PI_R / 2.0 * real'(ONE) + 0.5);
        k_gain    = 1.0;
        sc        = 1.0;
        for (int i = 0; i < STAGES; i++) begin
            atan_tab[i] = longint'($rtoi($atan(sc) * real'(ONE << GUARD) + 0.5));
            k_gain      = k_gain * $cos($atan(sc));
            sc          = sc / 2.0;
        end

        reset = 1'b1;  enable = 1'b1;  in_valid = 1'b0;
        in_angle = '0; in_tag = '0;
        tick();
        tick();
        reset = 1'b0;

        // Directed angles, including the +pi/2 fold boundary.
        directed("zero",      0,        5,  524288,  0);
        directed("half_pi",   823550,   6,  0,       524288);
        directed("p3q_pi",    1235324,  7, -370728,  370728);
        directed("n3q_pi",   -1235324,  8, -370728, -370728);

        // Fold boundaries and range ends, back to back.
        bnd = '{half_pi_m, half_pi_m + 1, -half_pi_m, -half_pi_m - 1,
                pi_m - 1, -pi_m, 1, -1};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;  in_angle = WIDTH'(bnd[i]);  in_tag = TAG_W'(200 + i);
            tick();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) tick();

        // 100 back-to-back random legal angles.
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;  in_angle = WIDTH'(rand_angle());  in_tag = TAG_W'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
        check("random_count", n_out - n0, 100);

        // Bubbles and a 5-cycle stall while results are emerging.
        for (int i = 0; i < 40; i++) begin
            enable   = !(i >= 22 && i < 27);
            in_valid = ($urandom_range(3, 0) != 0);
            in_angle = WIDTH'(rand_angle());
            in_tag   = TAG_W'(100 + i);
            tick();
        end
        enable   = 1'b1;
        in_valid = 1'b0;
        repeat (LAT + 2) tick();

        // Reset with 10 samples in flight. Reset wins over enable=0.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;  in_angle = WIDTH'(rand_angle());  in_tag = TAG_W'(50 + i);
            tick();
        end
        reset = 1'b1;  enable = 1'b0;
        tick();
        reset = 1'b0;  enable = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;  in_angle = WIDTH'(rand_angle());  in_tag = TAG_W'(80 + i);
            tick();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
        check("post_reset_count", n_out - n0, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
